mem_fetch_requester: RTL and testbench
======================================

MEM_FETCH_REQUESTER -- requirements
Module: mem_fetch_requester

Interface
REQ-001 SHALL have parameter p_opaq_bits, default 8: width of the memory opaque field.
REQ-002 SHALL have parameter p_max_in_flight, default 4: outstanding-request capacity; power of two, at most 2^p_opaq_bits.
REQ-003 SHALL have parameter p_reset_addr, default 32'h200: first fetch address.
REQ-004 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: the only clock.
- rst, in, 1: reset, synchronous and active-high.
- mem_req_val, out, 1: request valid.
- mem_req_rdy, in, 1: request ready.
- mem_req_op, out, 1: 0 = read; always 0.
- mem_req_opaque, out, p_opaq_bits: slot tag.
- mem_req_addr, out, 32: fetch address.
- mem_req_len, out, 2: 0 = 4 bytes; always 0.
- mem_req_data, out, 32: always 0.
- mem_resp_val, in, 1: response valid.
- mem_resp_rdy, out, 1: response ready.
- mem_resp_opaque, in, p_opaq_bits: returned tag.
- mem_resp_data, in, 32: instruction word.
- inst_val, out, 1: fetched instruction valid.
- inst_rdy, in, 1: downstream ready.
- inst, out, 32: instruction word.
- inst_pc, out, 32: address of that instruction.
- redirect_val, in, 1: squash and redirect.
- redirect_target, in, 32: new fetch address.

Function
REQ-005 SHALL hold fetch pc, a slot ring (head, tail, count) and per-slot {pc[31:0], live} table.
REQ-006 SHALL assert mem_req_val iff count < p_max_in_flight; mem_req_addr = pc; mem_req_opaque = tail (zero-extended).
REQ-007 SHALL, on request handshake, write {pc, live=1} to slot tail, tail++ (wraps modulo p_max_in_flight), count++, pc += 4 (wraps at 2^32).
REQ-008 SHALL treat responses as in-order; the response retires slot head.
REQ-009 SHALL, for a live head, drive inst_val = mem_resp_val && !redirect_val, inst = mem_resp_data, inst_pc = table[head].pc, mem_resp_rdy = inst_rdy && !redirect_val.
REQ-010 SHALL, for a non-live head, drive mem_resp_rdy = 1 and inst_val = 0, silently dropping the response.
REQ-011 SHALL, on response handshake, increment head and decrement count; a simultaneous request and response handshake SHALL leave count unchanged.
REQ-012 SHALL, on redirect_val, set pc = redirect_target next cycle and clear every live bit, including the slot allocated in that same cycle.
REQ-013 SHALL, on redirect_val, not forward any response that cycle; in-flight stale responses SHALL drain at one per cycle without stalling new requests.
REQ-014 SHALL produce inst output combinationally from the response, with zero added latency and no internal output buffer.
REQ-015 SHALL issue requests when count = p_max_in_flight-1 while a response retires the same cycle (full boundary).

Reset
REQ-016 SHALL, on rst, set pc = p_reset_addr, head = tail = count = 0 and all live bits = 0.
REQ-017 SHALL hold mem_req_val, inst_val and mem_resp_rdy at 0 while rst is high.
REQ-018 SHALL, after rst deasserts, issue the first request to p_reset_addr on the next cycle.
REQ-019 SHALL require the memory to discard outstanding requests on reset; requests in flight when rst asserts are lost.

Configuration
REQ-020 SHALL, when MEM_FETCH_ORDER_CHECK_EN is defined, raise $error and stop simulation on any response handshake where mem_resp_opaque != head or count = 0.
REQ-021 SHALL, when MEM_FETCH_ORDER_CHECK_EN is undefined, synthesize no check logic and use head only.

Structure
REQ-022 SHALL place the slot-table entry typedef {pc, live} and the MEM_OP_READ and MEM_LEN_WORD constants in shared package MemFetchPkg.
REQ-023 SHALL implement head, tail and count in one sub-module, mem_fetch_slot_ring, with alloc and retire strobes.

Verification
REQ-024 SHALL test reset then free-running memory: requests at 0x200, 0x204, 0x208 with opaque 0, 1, 2, and inst_pc matches in order.
REQ-025 SHALL test memory resp_val held low: exactly 4 requests issue and mem_req_val then stays 0 until one response retires.
REQ-026 SHALL test redirect to 0x400 with 3 outstanding: 3 responses dropped with inst_val = 0, and next inst_pc = 0x400.
REQ-027 SHALL test inst_rdy = 0 for 5 cycles: mem_resp_rdy = 0, no loss, and inst remains stable.
REQ-028 SHALL test redirect coincident with a request handshake at 0x20C: that response is dropped and the next request goes to the target.
REQ-029 SHALL test, with MEM_FETCH_ORDER_CHECK_EN, a response carrying opaque 1 when head = 0: the bench observes $error.

Source files
------------

// File: rtl/mem_fetch_requester_pkg.sv
// Shared types and constants for the instruction fetch requester.
// Holds the slot-table entry type, memory opcode/length constants and an index-width helper.
package MemFetchPkg;

    // One outstanding fetch: its address and whether it is still wanted.
    typedef struct packed {
        logic [31:0] pc;
        logic        live;
    } slot_t;

    localparam logic       MEM_OP_READ  = 1'b0;
    localparam logic [1:0] MEM_LEN_WORD = 2'd0;

    // Pointer width for a ring of the given depth (at least one bit).
    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mem_fetch_requester_slot_ring.sv
// Head/tail/count bookkeeping for the outstanding-fetch slot ring.
// Ports: clk, rst, alloc/retire strobes in; head, tail, full, empty out.
module mem_fetch_slot_ring
    import MemFetchPkg::*;
#(
    parameter int p_depth = 4,
    parameter int p_idx_bits = 2,
    parameter int p_cnt_bits = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc,
    input  logic                  retire,
    output logic [p_idx_bits-1:0] head,
    output logic [p_idx_bits-1:0] tail,
    output logic                  full,
    output logic                  empty
);

    logic [p_cnt_bits-1:0] count;
    logic                  do_alloc;
    logic                  do_retire;

    assign full      = (count == p_cnt_bits'(p_depth));
    assign empty     = (count == '0);
    assign do_alloc  = alloc && !full;
    // A response with nothing outstanding must not underflow the ring.
    assign do_retire = retire && !empty;

    function automatic logic [p_idx_bits-1:0] bump(
        input logic [p_idx_bits-1:0] p
    );
        return (p == p_idx_bits'(p_depth - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_alloc) begin
                tail <= bump(tail);
            end
            if (do_retire) begin
                head <= bump(head);
            end
            // Simultaneous alloc and retire leave the count unchanged.
            unique case ({do_alloc, do_retire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_fetch_requester.sv
// Instruction fetch requester: streams sequential word reads to memory and forwards in-order responses.
// Ports: clk, rst; mem_req_* out; mem_resp_* in; inst_* out; redirect_* in. Optional MEM_FETCH_ORDER_CHECK_EN.
module mem_fetch_requester
    import MemFetchPkg::*;
#(
    parameter int          p_opaq_bits     = 8,
    parameter int          p_max_in_flight = 4,
    parameter logic [31:0] p_reset_addr    = 32'h200
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   mem_req_val,
    input  logic                   mem_req_rdy,
    output logic                   mem_req_op,
    output logic [p_opaq_bits-1:0] mem_req_opaque,
    output logic [31:0]            mem_req_addr,
    output logic [1:0]             mem_req_len,
    output logic [31:0]            mem_req_data,
    input  logic                   mem_resp_val,
    output logic                   mem_resp_rdy,
    input  logic [p_opaq_bits-1:0] mem_resp_opaque,
    input  logic [31:0]            mem_resp_data,
    output logic                   inst_val,
    input  logic                   inst_rdy,
    output logic [31:0]            inst,
    output logic [31:0]            inst_pc,
    input  logic                   redirect_val,
    input  logic [31:0]            redirect_target
);

    localparam int IW = idx_bits(p_max_in_flight);
    localparam int CW = $clog2(p_max_in_flight + 1);

    logic [31:0] pc;
    slot_t       slots [p_max_in_flight];
    logic [IW-1:0] head;
    logic [IW-1:0] tail;
    logic        full;
    logic        empty;
    logic        head_live;
    logic        req_fire;
    logic        resp_fire;

    mem_fetch_slot_ring #(
        .p_depth    (p_max_in_flight),
        .p_idx_bits (IW),
        .p_cnt_bits (CW)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .alloc  (req_fire),
        .retire (resp_fire),
        .head   (head),
        .tail   (tail),
        .full   (full),
        .empty  (empty)
    );

    assign head_live = !empty && slots[head].live;
    assign req_fire  = mem_req_val && mem_req_rdy;
    assign resp_fire = mem_resp_val && mem_resp_rdy;

    always_comb begin
        mem_req_val    = !rst && !full;
        mem_req_op     = MEM_OP_READ;
        mem_req_opaque = p_opaq_bits'(tail);
        mem_req_addr   = pc;
        mem_req_len    = MEM_LEN_WORD;
        mem_req_data   = '0;
        inst           = mem_resp_data;
        inst_pc        = slots[head].pc;
        inst_val       = 1'b0;
        mem_resp_rdy   = 1'b0;
        if (!rst) begin
            if (head_live) begin
                inst_val     = mem_resp_val && !redirect_val;
                mem_resp_rdy = inst_rdy && !redirect_val;
            end else begin
                // Squashed slot: swallow the response.
                mem_resp_rdy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= p_reset_addr;
        end else if (redirect_val) begin
            pc <= redirect_target;
        end else if (req_fire) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < p_max_in_flight; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (resp_fire) begin
                slots[head].live <= 1'b0;
            end
            if (req_fire) begin
                slots[tail] <= '{pc: pc, live: 1'b1};
            end
            // Redirect also kills the slot allocated this same cycle.
            if (redirect_val) begin
                for (int i = 0; i < p_max_in_flight; i++) begin
                    slots[i].live <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_FETCH_ORDER_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst && resp_fire &&
            (empty || mem_resp_opaque != p_opaq_bits'(head))) begin
            $error("mem_fetch_requester: out-of-order response opaque=%0d head=%0d",
                   mem_resp_opaque, head);
            $finish;
        end
    end
`else
    logic unused_opaque;
    assign unused_opaque = ^mem_resp_opaque;
`endif

endmodule

// File: tb/tb_mem_fetch_requester.sv
// Self-checking bench for mem_fetch_requester.
// Queue-based reference model plus directed scenarios with literal expectations.
module tb_mem_fetch_requester;

    localparam int          CAP      = 4;
    localparam logic [31:0] RST_ADDR = 32'h200;

    logic        clk;
    logic        rst;
    logic        mem_req_val;
    logic        mem_req_rdy;
    logic        mem_req_op;
    logic [7:0]  mem_req_opaque;
    logic [31:0] mem_req_addr;
    logic [1:0]  mem_req_len;
    logic [31:0] mem_req_data;
    logic        mem_resp_val;
    logic        mem_resp_rdy;
    logic [7:0]  mem_resp_opaque;
    logic [31:0] mem_resp_data;
    logic        inst_val;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_val;
    logic [31:0] redirect_target;

    mem_fetch_requester dut (
        .clk             (clk),
        .rst             (rst),
        .mem_req_val     (mem_req_val),
        .mem_req_rdy     (mem_req_rdy),
        .mem_req_op      (mem_req_op),
        .mem_req_opaque  (mem_req_opaque),
        .mem_req_addr    (mem_req_addr),
        .mem_req_len     (mem_req_len),
        .mem_req_data    (mem_req_data),
        .mem_resp_val    (mem_resp_val),
        .mem_resp_rdy    (mem_resp_rdy),
        .mem_resp_opaque (mem_resp_opaque),
        .mem_resp_data   (mem_resp_data),
        .inst_val        (inst_val),
        .inst_rdy        (inst_rdy),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .redirect_val    (redirect_val),
        .redirect_target (redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int passed = 0;

    // Reference model: outstanding fetches in issue order.
    typedef struct { logic [31:0] pc; bit live; } mslot_t;
    mslot_t      mq[$];
    logic [31:0] mpc;
    int          mtail;

    // Memory: accepted requests awaiting a response, in order.
    typedef struct { logic [31:0] addr; logic [7:0] opq; } mreq_t;
    mreq_t memq[$];

    logic [31:0] req_addr_log[$];
    logic [31:0] req_opq_log[$];
    logic [31:0] inst_log[$];
    int          drops = 0;
    bit          resp_en = 0;
    bit          bad = 0;

    logic        s_req_val;
    logic        s_resp_rdy;
    logic        s_inst_val;
    logic [31:0] s_inst;
    logic [31:0] s_inst_pc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [31:0] word_for(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$],
                                         input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    // One clock: present memory response, check at negedge, advance model.
    task automatic step();
        logic        e_rv, e_rr, e_iv, live, rq, rs;
        if (resp_en && memq.size() > 0) begin
            mem_resp_val    = 1'b1;
            mem_resp_opaque = memq[0].opq ^ {7'd0, bad};
            mem_resp_data   = word_for(memq[0].addr);
        end else begin
            mem_resp_val    = 1'b0;
            mem_resp_opaque = 8'd0;
            mem_resp_data   = 32'hDEAD_BEEF;
        end
        @(negedge clk);
        live = (mq.size() > 0) && mq[0].live;
        e_rv = !rst && (mq.size() < CAP);
        e_iv = 1'b0;
        e_rr = 1'b0;
        if (!rst) begin
            if (live) begin
                e_iv = mem_resp_val && !redirect_val;
                e_rr = inst_rdy && !redirect_val;
            end else begin
                e_rr = 1'b1;
            end
        end
        chk("req_val", mem_req_val, e_rv);
        chk("resp_rdy", mem_resp_rdy, e_rr);
        chk("inst_val", inst_val, e_iv);
        if (e_rv) begin
            chk("req_addr", mem_req_addr, mpc);
            chk("req_opq", mem_req_opaque, mtail % CAP);
            chk("req_const", {mem_req_op, mem_req_len, mem_req_data}, 0);
        end
        if (e_iv) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst", inst, word_for(mq[0].pc));
        end
        s_req_val  = mem_req_val;
        s_resp_rdy = mem_resp_rdy;
        s_inst_val = inst_val;
        s_inst     = inst;
        s_inst_pc  = inst_pc;
        rq = mem_req_val && mem_req_rdy;
        rs = mem_resp_val && mem_resp_rdy;
        if (!rst && rs && !inst_val) drops++;
        if (inst_val && inst_rdy) inst_log.push_back(inst_pc);
        if (rq) begin
            req_addr_log.push_back(mem_req_addr);
            req_opq_log.push_back({24'd0, mem_req_opaque});
        end
        // Model update from the expected handshakes.
        if (rst) begin
            mq.delete();
            mpc   = RST_ADDR;
            mtail = 0;
            memq.delete();
        end else begin
            if (mem_resp_val && e_rr && mq.size() > 0) void'(mq.pop_front());
            if (e_rv && mem_req_rdy) begin
                mq.push_back('{pc: mpc, live: 1'b1});
                mtail++;
            end
            if (redirect_val) begin
                foreach (mq[i]) mq[i].live = 1'b0;
                mpc = redirect_target;
            end else if (e_rv && mem_req_rdy) begin
                mpc = mpc + 32'd4;
            end
            if (rs && memq.size() > 0) void'(memq.pop_front());
            if (rq) memq.push_back('{addr: mem_req_addr, opq: mem_req_opaque});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        mem_req_rdy = 1'b0;
        resp_en = 1'b1;
        for (int i = 0; i < 40 && memq.size() != 0; i++) step();
        chk("drain", memq.size(), 0);
    endtask

    initial begin
        int r0, i0, d0;
        rst = 1'b1;
        mem_req_rdy = 1'b1;
        inst_rdy = 1'b1;
        redirect_val = 1'b0;
        redirect_target = 32'd0;
        mem_resp_val = 1'b0;
        mem_resp_opaque = 8'd0;
        mem_resp_data = 32'd0;
        mpc = RST_ADDR;
        mtail = 0;
        @(posedge clk);
        #1;
        repeat (3) step();
        chk("rst_req_val", s_req_val, 0);
        chk("rst_resp_rdy", s_resp_rdy, 0);
        chk("rst_inst_val", s_inst_val, 0);

        // Free-running memory after reset.
        rst = 1'b0;
        resp_en = 1'b1;
        repeat (10) step();
        chk("first_addr0", qget(req_addr_log, 0), 32'h200);
        chk("first_addr1", qget(req_addr_log, 1), 32'h204);
        chk("first_addr2", qget(req_addr_log, 2), 32'h208);
        chk("first_opq0", qget(req_opq_log, 0), 0);
        chk("first_opq1", qget(req_opq_log, 1), 1);
        chk("first_opq2", qget(req_opq_log, 2), 2);
        chk("first_pc0", qget(inst_log, 0), 32'h200);
        chk("first_pc1", qget(inst_log, 1), 32'h204);
        chk("first_pc2", qget(inst_log, 2), 32'h208);

        // Responses withheld: ring fills to capacity and stalls.
        drain();
        mem_req_rdy = 1'b1;
        resp_en = 1'b0;
        r0 = req_addr_log.size();
        repeat (8) step();
        chk("full_issued", req_addr_log.size() - r0, 4);
        chk("full_stall", s_req_val, 0);
        resp_en = 1'b1;
        step();
        resp_en = 1'b0;
        step();
        chk("full_resume", s_req_val, 1);
        chk("full_issued2", req_addr_log.size() - r0, 5);

        // Redirect with three outstanding.
        drain();
        mem_req_rdy = 1'b1;
        resp_en = 1'b0;
        repeat (3) step();
        mem_req_rdy = 1'b0;
        redirect_val = 1'b1;
        redirect_target = 32'h400;
        step();
        redirect_val = 1'b0;
        d0 = drops;
        i0 = inst_log.size();
        mem_req_rdy = 1'b1;
        resp_en = 1'b1;
        repeat (12) step();
        chk("redir_drops", drops - d0, 3);
        chk("redir_pc", qget(inst_log, i0), 32'h400);

        // Downstream stall: response held, nothing accepted.
        inst_rdy = 1'b0;
        step();
        s_inst_pc = s_inst_pc;
        begin
            logic [31:0] hold_inst, hold_pc;
            hold_inst = s_inst;
            hold_pc = s_inst_pc;
            for (int k = 0; k < 5; k++) begin
                step();
                chk("stall_rdy", s_resp_rdy, 0);
                chk("stall_val", s_inst_val, 1);
                chk("stall_inst", s_inst, hold_inst);
            end
            inst_rdy = 1'b1;
            i0 = inst_log.size();
            step();
            chk("stall_noloss", qget(inst_log, i0), hold_pc);
        end

        // Redirect coincident with the request at 0x20C.
        rst = 1'b1;
        resp_en = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        mem_req_rdy = 1'b1;
        r0 = req_addr_log.size();
        repeat (3) step();
        redirect_val = 1'b1;
        redirect_target = 32'h800;
        step();
        redirect_val = 1'b0;
        d0 = drops;
        i0 = inst_log.size();
        resp_en = 1'b1;
        repeat (15) step();
        chk("co_addr", qget(req_addr_log, r0 + 3), 32'h20C);
        chk("co_opq", qget(req_opq_log, r0 + 3), 3);
        chk("co_next", qget(req_addr_log, r0 + 4), 32'h800);
        chk("co_drops", drops - d0, 4);
        chk("co_pc", qget(inst_log, i0), 32'h800);

`ifdef MEM_FETCH_ORDER_CHECK_EN
        // Wrong opaque at head 0: the design's order check ends the run.
        rst = 1'b1;
        resp_en = 1'b0;
        step();
        rst = 1'b0;
        step();
        mem_req_rdy = 1'b0;
        bad = 1'b1;
        resp_en = 1'b1;
        repeat (3) step();
        $display("FAIL order_check: no error raised for opaque 1 at head 0");
        total++;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
